// File: rtl/genram_pkg.sv
// Shared definitions for the genram_dp dual-port RAM: state encoding and
// byte-lane helpers.
package genram_pkg;

  localparam logic [0:0] GENRAM_CLEAR = 1'b0;
  localparam logic [0:0] GENRAM_RUN   = 1'b1;

  function automatic int genram_nb(input int dw);
    return dw / 8;
  endfunction

  function automatic bit genram_dw_ok(input int dw);
    return (dw % 8) == 0;
  endfunction

endpackage

// File: rtl/genram_clr_ctrl.sv
// Post-reset clear sweep for genram_dp: CLEAR/RUN FSM, clr_addr counter,
// busy, and the write-port mux that selects between the sweep and the user.
module genram_clr_ctrl
  import genram_pkg::*;
#(
  parameter int AW = 4,
  parameter int NB = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [NB-1:0] wbe,
  output logic          busy,
  output logic          sel_clr,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [NB-1:0] mem_wbe
);

  logic [0:0]    state;
  logic [AW-1:0] clr_addr;

  // Single terminal-count compare; the counter parks on the last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GENRAM_CLEAR;
      clr_addr <= '0;
    end else if (state == GENRAM_CLEAR) begin
      if (&clr_addr) state    <= GENRAM_RUN;
      else           clr_addr <= clr_addr + AW'(1);
    end
  end

  assign busy      = (state == GENRAM_CLEAR);
  assign sel_clr   = busy;
  assign mem_we    = busy ? 1'b1     : we;
  assign mem_waddr = busy ? clr_addr : waddr;
  assign mem_wbe   = busy ? '1       : wbe;

endmodule

// File: rtl/genram_dp.sv
// Simple-dual-port RAM with byte-write enables, registered read and a
// post-reset clear sweep. Define GENRAM_BYPASS_EN for write-first collisions.
module genram_dp
  import genram_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            busy,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW/8-1:0] wbe,
  input  logic [DW-1:0]   wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata,
  output logic            rvalid
);

  localparam int NB    = genram_nb(DW);
  localparam int DEPTH = 2 ** AW;

  if (!genram_dw_ok(DW)) begin : g_dw_chk
    $error("genram_dp: DW must be a multiple of 8");
  end

  logic [NB-1:0][7:0] mem [DEPTH];
  logic [NB-1:0][7:0] wdata_l;
  logic [NB-1:0][7:0] wr_word;
  logic [NB-1:0][7:0] rd_word;
  logic               sel_clr;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [NB-1:0]      mem_wbe;

  genram_clr_ctrl #(.AW(AW), .NB(NB)) u_clr (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wbe       (wbe),
    .busy      (busy),
    .sel_clr   (sel_clr),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wbe   (mem_wbe)
  );

  assign wdata_l = wdata;
  assign wr_word = sel_clr ? '0 : wdata_l;

  // Array has no reset; the sweep is the only thing that clears it.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    always_ff @(posedge clk) begin
      if (mem_we && mem_wbe[i]) mem[mem_waddr][i] <= wr_word[i];
    end
  end

`ifdef GENRAM_BYPASS_EN
  always_comb begin
    rd_word = mem[raddr];
    if (we && (waddr == raddr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) rd_word[i] = wdata_l[i];
      end
    end
  end
`else
  assign rd_word = mem[raddr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (!busy && re) begin
      rdata  <= rd_word;
      rvalid <= 1'b1;
    end else begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_genram_dp.sv
// Self-checking bench for genram_dp (AW=4, DW=32) against a behavioural model.
module tb_genram_dp;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 16;
`ifdef GENRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re;
  logic [3:0]  waddr, raddr, wbe;
  logic [31:0] wdata;
  logic        busy, rvalid;
  logic [31:0] rdata;

  genram_dp #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .busy(busy), .we(we), .waddr(waddr),
    .wbe(wbe), .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata),
    .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  logic [31:0] model_mem [DEPTH];
  int          sweep_left;
  logic [31:0] exp_rdata;
  logic        exp_rvalid;
  int          checks = 0;
  int          errors = 0;

  task automatic idle();
    we = 0; re = 0; wbe = 0; waddr = 0; raddr = 0; wdata = 0;
  endtask

  task automatic model_reset();
    sweep_left = DEPTH;
    exp_rdata  = 0;
    exp_rvalid = 0;
  endtask

  // One clock edge; the model applies the behavioural rules to the inputs
  // present at that edge, and outputs are then sampled on the falling edge.
  task automatic tick();
    logic [31:0] old_w, merged;
    @(posedge clk);
    if (sweep_left > 0) begin
      model_mem[DEPTH - sweep_left] = 0;
      sweep_left--;
      exp_rvalid = 0;
    end else begin
      old_w  = model_mem[raddr];
      merged = old_w;
      for (int b = 0; b < 4; b++) if (wbe[b]) merged[8*b +: 8] = wdata[8*b +: 8];
      if (re) begin
        exp_rvalid = 1;
        exp_rdata  = (we && waddr == raddr && BYP) ? merged : old_w;
      end else begin
        exp_rvalid = 0;
      end
      if (we)
        for (int b = 0; b < 4; b++)
          if (wbe[b]) model_mem[waddr][8*b +: 8] = wdata[8*b +: 8];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b want 1", busy); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0b want 0", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    @(negedge clk);
    rst_n = 1;
    for (int e = 1; e <= DEPTH; e++) begin
      if (e == 5) begin
        we = 1; waddr = 3; wdata = 32'hDEADBEEF; wbe = 4'hF; re = 1; raddr = 3;
      end else idle();
      tick();
      checks++;
      if (busy !== (e < DEPTH)) begin errors++; $display("FAIL sweep_busy edge %0d got %0b want %0b", e, busy, e < DEPTH); end
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL sweep_rvalid edge %0d got %0b want 0", e, rvalid); end
    end
    re = 1; raddr = 1; tick();
    checks++; if (rdata !== 32'h0 || rvalid !== 1'b1) begin errors++; $display("FAIL first_read got %h/%0b want 00000000/1", rdata, rvalid); end
    idle(); tick();
    checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL rdata_hold got %h/%0b want 00000000/0", rdata, rvalid); end
    re = 1; raddr = 3; tick();
    checks++; if (rdata !== 32'h0 || rvalid !== 1'b1) begin errors++; $display("FAIL dropped_write got %h want 00000000", rdata); end
    idle();
  endtask

  task automatic test_full_write();
    we = 1; waddr = 1; wdata = 32'hFFFFFFFF; wbe = 4'hF; tick();
    idle(); re = 1; raddr = 1; tick();
    checks++; if (rdata !== 32'hFFFFFFFF || rdata !== exp_rdata) begin errors++; $display("FAIL full_write got %h want ffffffff", rdata); end
    idle();
  endtask

  task automatic test_partial_write();
    we = 1; waddr = 4; wdata = 32'hFFFFFFFF; wbe = 4'hF; tick();
    wdata = 32'h12345678; wbe = 4'h3; tick();
    idle(); re = 1; raddr = 4; tick();
    checks++; if (rdata !== 32'hFFFF5678) begin errors++; $display("FAIL partial_write got %h want ffff5678", rdata); end
    idle(); we = 1; waddr = 4; wdata = 32'h0; wbe = 4'h0; tick();
    idle(); re = 1; raddr = 4; tick();
    checks++; if (rdata !== 32'hFFFF5678) begin errors++; $display("FAIL wbe_zero got %h want ffff5678", rdata); end
    idle();
  endtask

  task automatic test_collision();
    logic [31:0] want;
    we = 1; waddr = 2; wdata = 32'hAAAAAAAA; wbe = 4'hF; tick();
    wdata = 32'h55555555; re = 1; raddr = 2; tick();
    want = BYP ? 32'h55555555 : 32'hAAAAAAAA;
    checks++; if (rdata !== want || rvalid !== 1'b1) begin errors++; $display("FAIL collision got %h want %h", rdata, want); end
    idle(); re = 1; raddr = 2; tick();
    checks++; if (rdata !== 32'h55555555) begin errors++; $display("FAIL after_collision got %h want 55555555", rdata); end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < DEPTH; a++) begin
      re = 1; raddr = a[3:0]; tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_rdata) begin
        errors++; $display("FAIL b2b_read addr %0d got %h/%0b want %h/1", a, rdata, rvalid, exp_rdata);
      end
    end
    idle(); tick();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end got %0b want 0", rvalid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom); re = 1'($urandom);
      waddr = 4'($urandom_range(0, 3)); raddr = 4'($urandom_range(0, 3));
      if (n[0]) begin waddr = 4'($urandom); raddr = 4'($urandom); end
      wbe = 4'($urandom); wdata = $urandom;
      tick();
      checks++;
      if (rvalid !== exp_rvalid || rdata !== exp_rdata) begin
        errors++; $display("FAIL random cyc %0d got %h/%0b want %h/%0b", n, rdata, rvalid, exp_rdata, exp_rvalid);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    we = 1; waddr = 1; wdata = 32'hFFFFFFFF; wbe = 4'hF; tick();
    idle(); re = 1; raddr = 1; tick();
    checks++; if (rdata !== 32'hFFFFFFFF || rvalid !== 1'b1) begin errors++; $display("FAIL premid got %h/%0b want ffffffff/1", rdata, rvalid); end
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++; if (rdata !== 32'h0 || rvalid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_reset got %h/%0b/%0b want 00000000/0/1", rdata, rvalid, busy);
    end
    idle();
    @(negedge clk); rst_n = 1;
    for (int e = 1; e <= DEPTH; e++) begin
      if (e == 3) begin re = 1; raddr = 1; end else idle();
      tick();
      checks++;
      if (busy !== (e < DEPTH) || rvalid !== 1'b0) begin errors++; $display("FAIL resweep edge %0d got %0b/%0b", e, busy, rvalid); end
    end
    re = 1; raddr = 1; tick();
    checks++; if (rdata !== 32'h0 || rvalid !== 1'b1) begin errors++; $display("FAIL resweep_read got %h/%0b want 00000000/1", rdata, rvalid); end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_partial_write();
    test_collision();
    test_back_to_back();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/genram_dp.md
# genram_dp

Parametrised simple-dual-port RAM: one write port with per-byte enables and one read port with a registered, one-cycle-latency read. After every reset it runs a hardware clear sweep that zeroes every word, and it flags that sweep on `busy`. It is the general-purpose data/register-file storage for the MIPS datapath, replacing the single-port `rw`-multiplexed RAM.

## Interface

**Parameters**
- `AW`, default 4: address width; depth is 2^AW words.
- `DW`, default 32: data width. Must be a multiple of 8. Derived `NB = DW/8` byte lanes.

**Ports**
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `busy`  out  1  high while the clear sweep runs. Requests are ignored while it is high.
- `we`  in  1  write request.
- `waddr`  in  AW  write address.
- `wbe`  in  NB  byte-write enables; bit i covers `wdata[8i+7:8i]`.
- `wdata`  in  DW  write data.
- `re`  in  1  read request.
- `raddr`  in  AW  read address.
- `rdata`  out  DW  registered read data. Holds its value between reads.
- `rvalid`  out  1  one-cycle pulse marking a new `rdata`.

## Operation

**FSM states**
- CLEAR: a counter `clr_addr` starts at 0. Each rising edge writes all-zero to `mem[clr_addr]` and increments the counter.
- On the edge that writes address 2^AW-1, the FSM goes to RUN and `busy` falls.
- RUN: the normal operating state. RUN has no exit except reset.

**Reset**
- The memory array is not reset directly; only the sweep clears it.
- Reset asserted mid-sweep or mid-operation aborts everything and restarts CLEAR from address 0.

**Requests in RUN**
- Write: on an edge with `we=1`, each lane with `wbe[i]=1` updates `mem[waddr]`. Lanes with `wbe[i]=0` keep their contents. `wbe=0` makes the write a no-op.
- Read: on an edge with `re=1`, `rdata <= mem[raddr]` and `rvalid <= 1`.
- With `re=0`: `rvalid <= 0` and `rdata` holds.
- Reads and writes are independent. Both may occur on the same edge.

**Requests in CLEAR**
- `we` and `re` are dropped without effect.
- `rvalid` stays 0.

**Collision** (`we` and `re` on the same edge with `waddr == raddr`)
- The default is read-first: `rdata` returns the old word (see Configuration).

**Wrap-around**
- Addresses are exactly AW bits, so every address is in range.
- `clr_addr` has one terminal-count compare at 2^AW-1. It never wraps back into a second sweep.

## Timing

**Reset values** (applied asynchronously while `rst_n=0`)
- `busy=1`, `rdata=0`, `rvalid=0`.
- State CLEAR, `clr_addr=0`.

**Clear sweep**
- The first edge after `rst_n` rises writes address 0.
- `busy` is low after edge 2^AW (16 for AW=4).
- The first request that takes effect is sampled on edge 2^AW+1.

**Latencies**
- Read latency: request sampled on edge N → `rdata`/`rvalid` valid after edge N, for the whole cycle N..N+1.
- Write latency: data written on edge N is readable by a read sampled on edge N+1.
- Back-to-back reads every cycle are allowed: `rvalid` stays high, and `rdata` updates each cycle.

## Configuration

- Macro: `GENRAM_BYPASS_EN`.
- **Defined:** write-to-read forwarding is enabled. On a same-edge, same-address collision, `rdata` returns the byte-merged word: `wdata` lanes where `wbe=1`, old `mem` lanes otherwise. This makes the RAM write-first.
- **Undefined:** the RAM is read-first, with no forwarding logic, and returns the old word.
- Either way, sweep and latency behaviour are identical.

## Structure

- Shared package `genram_pkg` holds:
  - the state encoding (`GENRAM_CLEAR`, `GENRAM_RUN`);
  - the byte-lane count helper (`DW/8`);
  - a compile-time check that `DW % 8 == 0`.
- Sub-module `genram_clr_ctrl` contains the CLEAR/RUN FSM, `clr_addr` counter and `busy`. It drives the internal write mux: sweep port vs. user port.
- The top `genram_dp` holds the array, the byte-lane write logic, the read register and the optional bypass mux.

## Test plan

All scenarios use AW=4, DW=32.

1. **Reset and sweep:** pulse `rst_n` low, release → `busy=1` for exactly 16 edges then 0. Read addr 1 → `rdata=0x00000000`, `rvalid` high for one cycle.
2. **Full-word write:** write addr 1 with `0xFFFFFFFF`, `wbe=0xF`. Read addr 1 on the next edge → `rdata=0xFFFFFFFF` one edge later.
3. **Partial write:** addr 4 holds `0xFFFFFFFF`. Write `0x12345678` with `wbe=0x3`, then read addr 4 → `0xFFFF5678`. Write `wbe=0x0` → the value is unchanged.
4. **Collision:** addr 2 holds `0xAAAAAAAA`. Write `0x55555555`, `wbe=0xF` while reading addr 2 on the same edge → `0xAAAAAAAA` without `GENRAM_BYPASS_EN`, `0x55555555` with it. A following read returns `0x55555555` in both builds.
5. **Requests during sweep:** during sweep edge 5, issue write addr 3 `0xDEADBEEF` plus a read → `rvalid` stays 0. After `busy` falls, read addr 3 → `0x00000000`.
6. **Reset mid-operation:** with `rvalid=1` and `rdata=0xFFFFFFFF`, drop `rst_n` between edges → `rdata=0`, `rvalid=0`, `busy=1` immediately. After release and a 16-edge sweep, addr 1 reads `0x00000000`.
